assoc_search: RTL and testbench



---
 rtl/hdc_pkg.sv | 22 ++
 rtl/chunk_popcount.sv | 20 ++
 rtl/assoc_search.sv | 127 ++++++++++++
 tb/tb_assoc_search.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared HDC package.
//   label_t        : class label, 0 = non-seizure, 1 = seizure
//   search_state_t : associative-search FSM states
//   ceil_div       : integer ceiling division used to size the chunk count
package hdc_pkg;

  typedef enum logic {
    LABEL_NONSEIZURE = 1'b0,
    LABEL_SEIZURE    = 1'b1
  } label_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } search_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of a PAR_BITS-wide vector.
//   i_vec   : input bits
//   o_count : number of ones in i_vec
module chunk_popcount #(
  parameter  int PAR_BITS = 2,
  localparam int PW       = $clog2(PAR_BITS + 1)
) (
  input  logic [PAR_BITS-1:0] i_vec,
  output logic [PW-1:0]       o_count
);

  // Sum the individual bits
  always_comb begin
    o_count = '0;
    for (int i = 0; i < PAR_BITS; i++) begin
      o_count = o_count + PW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/assoc_search.sv
// Associative search: Hamming distance of a query HV to two class HVs,
// PAR_BITS bits per cycle, nearer class reported as the predicted label.
//   clk, rst              : clock, synchronous active-high reset
//   en                    : start strobe, only honoured in IDLE
//   hv_query              : query HV, latched on an accepted start
//   class_hv_nonseizure   : class 0 HV, read live during the search
//   class_hv_seizure      : class 1 HV, read live during the search
//   busy                  : search in progress (through the done cycle)
//   done                  : one-cycle result strobe
//   label_out             : 0 = non-seizure, 1 = seizure (ties -> 0)
//   dist_nonseizure/seizure : Hamming distances, held until next result
module assoc_search
  import hdc_pkg::*;
#(
  parameter  int DIMENSIONS = 6,
  parameter  int PAR_BITS   = 2,
  localparam int DW         = $clog2(DIMENSIONS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIMENSIONS-1:0] hv_query,
  input  logic [DIMENSIONS-1:0] class_hv_nonseizure,
  input  logic [DIMENSIONS-1:0] class_hv_seizure,
  output logic                  busy,
  output logic                  done,
  output logic                  label_out,
  output logic [DW-1:0]         dist_nonseizure,
  output logic [DW-1:0]         dist_seizure
);

  localparam int NCHUNK = ceil_div(DIMENSIONS, PAR_BITS);
  localparam int PADW   = NCHUNK * PAR_BITS;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = $clog2(PAR_BITS + 1);

  search_state_t         r_state;
  logic [DIMENSIONS-1:0] r_query;
  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_acc0;
  logic [DW-1:0]         r_acc1;
  logic [DW-1:0]         r_dist0;
  logic [DW-1:0]         r_dist1;
  label_t                r_label;
  logic                  r_busy;
  logic                  r_done;

  // Zero padding above DIMENSIONS makes the XOR of padded bits zero,
  // so the last partial chunk never counts bits that do not exist.
  logic [PADW-1:0]     w_query_pad;
  logic [PADW-1:0]     w_c0_pad;
  logic [PADW-1:0]     w_c1_pad;
  logic [PAR_BITS-1:0] w_diff0;
  logic [PAR_BITS-1:0] w_diff1;
  logic [PW-1:0]       w_pop0;
  logic [PW-1:0]       w_pop1;

  assign w_query_pad = PADW'(r_query);
  assign w_c0_pad    = PADW'(class_hv_nonseizure);
  assign w_c1_pad    = PADW'(class_hv_seizure);
  assign w_diff0     = w_query_pad[r_cnt*PAR_BITS +: PAR_BITS] ^ w_c0_pad[r_cnt*PAR_BITS +: PAR_BITS];
  assign w_diff1     = w_query_pad[r_cnt*PAR_BITS +: PAR_BITS] ^ w_c1_pad[r_cnt*PAR_BITS +: PAR_BITS];

  chunk_popcount #(.PAR_BITS(PAR_BITS)) u_pop0 (.i_vec(w_diff0), .o_count(w_pop0));
  chunk_popcount #(.PAR_BITS(PAR_BITS)) u_pop1 (.i_vec(w_diff1), .o_count(w_pop1));

  // Search FSM with accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_query <= '0;
      r_cnt   <= '0;
      r_acc0  <= '0;
      r_acc1  <= '0;
      r_dist0 <= '0;
      r_dist1 <= '0;
      r_label <= LABEL_NONSEIZURE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (en) begin
            r_query <= hv_query;
            r_acc0  <= '0;
            r_acc1  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ACCUM: begin
          r_acc0 <= r_acc0 + DW'(w_pop0);
          r_acc1 <= r_acc1 + DW'(w_pop1);
          if (r_cnt == CW'(NCHUNK - 1)) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_dist0 <= r_acc0;
          r_dist1 <= r_acc1;
          // Strict compare: a tie resolves to non-seizure
          r_label <= (r_acc1 < r_acc0) ? LABEL_SEIZURE : LABEL_NONSEIZURE;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign label_out       = r_label;
  assign dist_nonseizure = r_dist0;
  assign dist_seizure    = r_dist1;

endmodule

// File: tb/tb_assoc_search.sv
// Scoreboard bench for assoc_search (D=6,P=2 main instance; D=7,P=2 padding instance).
module tb_assoc_search;

  localparam int N6 = 3;  // ceil(6/2)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [5:0] q   = '0;
  logic [5:0] c0  = 6'b000001;
  logic [5:0] c1  = 6'b111110;
  logic       busy, done, label_out;
  logic [2:0] d0, d1;

  logic       en7 = 1'b0;
  logic [6:0] q7  = '0;
  logic [6:0] c07 = 7'b0000001;
  logic [6:0] c17 = 7'b1111110;
  logic       busy7, done7, label7;
  logic [2:0] d07, d17;

  always #5 clk = ~clk;

  assoc_search #(.DIMENSIONS(6), .PAR_BITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .hv_query(q),
    .class_hv_nonseizure(c0), .class_hv_seizure(c1),
    .busy(busy), .done(done), .label_out(label_out),
    .dist_nonseizure(d0), .dist_seizure(d1)
  );

  assoc_search #(.DIMENSIONS(7), .PAR_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .en(en7), .hv_query(q7),
    .class_hv_nonseizure(c07), .class_hv_seizure(c17),
    .busy(busy7), .done(done7), .label_out(label7),
    .dist_nonseizure(d07), .dist_seizure(d17)
  );

  typedef struct {
    int due;
    int e0;
    int e1;
    int lbl;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;
  int   last_acc = -1;
  int   next_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus; the bench's protocol model decides acceptance
  task automatic step(input logic e, input logic [5:0] qq, input logic r);
    int a, b;
    en = e; q = qq; rst = r;
    @(posedge clk); #1;
    if (r) begin
      sb.delete();
      last_acc = -1;
      next_acc = cyc + 1;
    end else if (e && cyc >= next_acc) begin
      a = $countones(qq ^ c0);
      b = $countones(qq ^ c1);
      sb.push_back('{due: cyc + N6 + 1, e0: a, e1: b, lbl: (b < a) ? 1 : 0});
      last_acc = cyc;
      next_acc = cyc + N6 + 2;
    end
  endtask

  // Monitor: busy against the protocol model, results against the scoreboard
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("busy", int'(busy), (last_acc >= 0 && cyc >= last_acc && cyc <= last_acc + N6 + 1) ? 1 : 0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("done_cycle", cyc, x.due);
          check("dist_nonseizure", int'(d0), x.e0);
          check("dist_seizure", int'(d1), x.e1);
          check("label_out", int'(label_out), x.lbl);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_done", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  task automatic run7(input logic [6:0] qq);
    int start, got, a, b;
    got = 0;
    en7 = 1'b1; q7 = qq;
    @(posedge clk); #1;
    en7 = 1'b0; q7 = $urandom;
    start = cyc;
    a = $countones(qq ^ c07);
    b = $countones(qq ^ c17);
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(negedge clk);
      if (done7 === 1'b1) got = 1;
    end
    check("d7_done_seen", got, 1);
    if (got == 1) begin
      check("d7_latency", cyc - start, 5);
      check("d7_dist_nonseizure", int'(d07), a);
      check("d7_dist_seizure", int'(d17), b);
      check("d7_label", int'(label7), (b < a) ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    step(1'b0, 6'd0, 1'b1);
    step(1'b0, 6'd0, 1'b1);
    step(1'b0, 6'd0, 1'b0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_label", int'(label_out), 0);
    check("rst_d0", int'(d0), 0);
    check("rst_d1", int'(d1), 0);

    // Directed: 1/5/0, 5/1/1, tie 3/3/0
    step(1'b1, 6'b000000, 1'b0); idle(N6 + 3);
    step(1'b1, 6'b111111, 1'b0); idle(N6 + 3);
    step(1'b1, 6'b011101, 1'b0); idle(N6 + 3);

    // en held high with changing queries: only E0 and E0+N+2 accepted
    step(1'b1, 6'b110100, 1'b0);
    for (int i = 0; i < N6 + 2; i++) step(1'b1, $urandom, 1'b0);
    idle(N6 + 3);

    // Reset in the 2nd ACCUM cycle after a label=1 result
    step(1'b1, 6'b111111, 1'b0); idle(N6 + 3);
    step(1'b1, 6'b101010, 1'b0);
    step(1'b0, 6'b000000, 1'b0);
    step(1'b0, 6'b000000, 1'b1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_label", int'(label_out), 0);
    check("midrst_d0", int'(d0), 0);
    check("midrst_d1", int'(d1), 0);
    idle(8);
    step(1'b1, 6'b111000, 1'b0); idle(N6 + 3);

    // Randomized traffic; classes change only while idle
    for (int i = 0; i < 400; i++) begin
      if ((last_acc < 0 || cyc > last_acc + N6 + 1) && $urandom_range(0, 9) == 0) begin
        c0 = $urandom;
        c1 = $urandom;
      end
      step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, $urandom, 1'b0);
    end
    idle(N6 + 4);
    check("scoreboard_empty", sb.size(), 0);

    // D=7: padded bit beyond the vector must not count
    run7(7'b1000000);
    for (int i = 0; i < 4; i++) run7($urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
